// File: rtl/tmvp_pkg.sv
// tmvp_pkg
//   Shared definitions for the TMVP job sequencer, the TMVP core and its bench:
//   the sequencer state enum and the default operand geometry.
package tmvp_pkg;

    localparam int TMVP_N          = 512;  // padded operand length (BRAM depth)
    localparam int TMVP_REAL_N     = 509;  // real coefficients per operand
    localparam int TMVP_DATA_WIDTH = 8;    // coefficient width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_F,
        ST_PAD_F,
        ST_LOAD_G,
        ST_PAD_G,
        ST_START,
        ST_RUN,
        ST_FIN
    } seq_state_e;

endpackage

// File: rtl/tmvp_bram_port_mux.sv
// tmvp_bram_port_mux
//   Combinational owner selection for the f/g operand BRAM ports.
//   Ports:
//     core_phase             sequencer is in START/RUN (core owns the BRAMs)
//     ld_pending             a registered loader write is still being presented
//     ld_addr, ld_f_we/g_we  loader port-a address and write enables
//     core_*_addr_*          core read addresses
//     f/g_addr_a/b, f/g_we_a BRAM address and write-enable pins
module tmvp_bram_port_mux #(
    parameter int AW = 9
) (
    input  logic          core_phase,
    input  logic          ld_pending,
    input  logic [AW-1:0] ld_addr,
    input  logic          ld_f_we,
    input  logic          ld_g_we,
    input  logic [AW-1:0] core_f_addr_a,
    input  logic [AW-1:0] core_f_addr_b,
    input  logic [AW-1:0] core_g_addr_a,
    input  logic [AW-1:0] core_g_addr_b,
    output logic [AW-1:0] f_addr_a,
    output logic [AW-1:0] f_addr_b,
    output logic [AW-1:0] g_addr_a,
    output logic [AW-1:0] g_addr_b,
    output logic          f_we_a,
    output logic          g_we_a
);

    // The loader write path is registered, so the final g word is still on
    // port a during the first START cycle. Port a stays with the loader until
    // that write has landed; the core cannot be started before then anyway.
    logic core_a;
    assign core_a = core_phase && !ld_pending;

    assign f_addr_a = core_a ? core_f_addr_a : ld_addr;
    assign g_addr_a = core_a ? core_g_addr_a : ld_addr;
    assign f_we_a   = core_a ? 1'b0 : ld_f_we;
    assign g_we_a   = core_a ? 1'b0 : ld_g_we;

    assign f_addr_b = core_phase ? core_f_addr_b : '0;
    assign g_addr_b = core_phase ? core_g_addr_b : '0;

endmodule

// File: rtl/tmvp_job_sequencer.sv
// tmvp_job_sequencer
//   Runs one TMVP job: streams f then g into their BRAMs (zero-padding each
//   from REAL_N to N words), pulses the core start, counts core output beats
//   and reports completion with a beat-count check.
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     s_axis_*                    operand coefficient stream (f first, then g)
//     core_start/ready/done       core handshake
//     core_tvalid                 core output beat strobe (counted only)
//     core_*_addr_*               core BRAM read addresses
//     f/g_addr_a/b, f/g_we_a,
//     f/g_data_a                  BRAM port pins
//     busy, job_done, job_err,
//     beat_count                  job status
module tmvp_job_sequencer
    import tmvp_pkg::*;
#(
    parameter int N          = TMVP_N,
    parameter int REAL_N     = TMVP_REAL_N,
    parameter int DATA_WIDTH = TMVP_DATA_WIDTH,
    parameter int AW         = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic                   core_start,
    input  logic                   core_ready,
    input  logic                   core_done,
    input  logic                   core_tvalid,
    input  logic [AW-1:0]          core_f_addr_a,
    input  logic [AW-1:0]          core_f_addr_b,
    input  logic [AW-1:0]          core_g_addr_a,
    input  logic [AW-1:0]          core_g_addr_b,
    output logic [AW-1:0]          f_addr_a,
    output logic [AW-1:0]          f_addr_b,
    output logic [AW-1:0]          g_addr_a,
    output logic [AW-1:0]          g_addr_b,
    output logic                   f_we_a,
    output logic                   g_we_a,
    output logic [DATA_WIDTH-1:0]  f_data_a,
    output logic [DATA_WIDTH-1:0]  g_data_a,
    output logic                   busy,
    output logic                   job_done,
    output logic                   job_err,
    output logic [$clog2(N+1)-1:0] beat_count
);

    localparam int            BCW       = $clog2(N+1);
    localparam logic [AW-1:0] LAST_REAL = AW'(REAL_N - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam bit            PAD_EN    = (REAL_N < N);

    seq_state_e            state, state_next;
    logic [AW-1:0]         cnt, cnt_next;
    logic                  hs;
    logic                  wr_f, wr_g;
    logic [DATA_WIDTH-1:0] wr_val;
    logic                  start_fire, done_fire;
    logic [BCW-1:0]        bc_run;

    logic [AW-1:0]         ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_f_we, ld_g_we;

    assign s_axis_tready = !reset &&
                           (state == ST_IDLE || state == ST_LOAD_F || state == ST_LOAD_G);
    assign hs = s_axis_tready && s_axis_tvalid;

    // Beat count including a beat that coincides with core_done, saturating at N.
    always_comb begin
        bc_run = beat_count;
        if (core_tvalid && beat_count != BCW'(N))
            bc_run = beat_count + BCW'(1);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_f       = 1'b0;
        wr_g       = 1'b0;
        wr_val     = s_axis_tdata;
        start_fire = 1'b0;
        done_fire  = 1'b0;
        case (state)
            // IDLE holds cnt at 0, so its first beat is simply the first LOAD_F beat.
            ST_IDLE, ST_LOAD_F: begin
                if (hs) begin
                    wr_f = 1'b1;
                    if (cnt == LAST_REAL) begin
                        cnt_next   = PAD_EN ? cnt + AW'(1) : '0;
                        state_next = PAD_EN ? ST_PAD_F : ST_LOAD_G;
                    end else begin
                        cnt_next   = cnt + AW'(1);
                        state_next = ST_LOAD_F;
                    end
                end
            end
            ST_PAD_F: begin
                wr_f   = 1'b1;
                wr_val = '0;
                if (cnt == LAST_ADDR) begin
                    cnt_next   = '0;
                    state_next = ST_LOAD_G;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            ST_LOAD_G: begin
                if (hs) begin
                    wr_g = 1'b1;
                    if (cnt == LAST_REAL) begin
                        cnt_next   = PAD_EN ? cnt + AW'(1) : '0;
                        state_next = PAD_EN ? ST_PAD_G : ST_START;
                    end else begin
                        cnt_next = cnt + AW'(1);
                    end
                end
            end
            ST_PAD_G: begin
                wr_g   = 1'b1;
                wr_val = '0;
                if (cnt == LAST_ADDR) begin
                    cnt_next   = '0;
                    state_next = ST_START;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            ST_START: begin
                if (core_ready) begin
                    start_fire = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    done_fire  = 1'b1;
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_addr    <= '0;
            ld_data    <= '0;
            ld_f_we    <= 1'b0;
            ld_g_we    <= 1'b0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            job_done   <= 1'b0;
            job_err    <= 1'b0;
            beat_count <= '0;
        end else begin
            ld_f_we    <= wr_f;
            ld_g_we    <= wr_g;
            if (wr_f || wr_g) begin
                ld_addr <= cnt;
                ld_data <= wr_val;
            end
            core_start <= start_fire;
            busy       <= (state_next != ST_IDLE);
            job_done   <= done_fire;
            job_err    <= done_fire && (bc_run != BCW'(REAL_N));
            if (start_fire)
                beat_count <= '0;
            else if (state == ST_RUN)
                beat_count <= bc_run;
        end
    end

    assign f_data_a = ld_data;
    assign g_data_a = ld_data;

    tmvp_bram_port_mux #(.AW(AW)) u_mux (
        .core_phase    (state == ST_START || state == ST_RUN),
        .ld_pending    (ld_f_we || ld_g_we),
        .ld_addr       (ld_addr),
        .ld_f_we       (ld_f_we),
        .ld_g_we       (ld_g_we),
        .core_f_addr_a (core_f_addr_a),
        .core_f_addr_b (core_f_addr_b),
        .core_g_addr_a (core_g_addr_a),
        .core_g_addr_b (core_g_addr_b),
        .f_addr_a      (f_addr_a),
        .f_addr_b      (f_addr_b),
        .g_addr_a      (g_addr_a),
        .g_addr_b      (g_addr_b),
        .f_we_a        (f_we_a),
        .g_we_a        (g_we_a)
    );

endmodule

// File: tb/tb_tmvp_job_sequencer.sv
module tb_tmvp_job_sequencer;
    import tmvp_pkg::*;

    localparam int N   = TMVP_N;
    localparam int R   = TMVP_REAL_N;
    localparam int DW  = TMVP_DATA_WIDTH;
    localparam int AW  = $clog2(N);
    localparam int BCW = $clog2(N+1);

    logic           clk, reset;
    logic [DW-1:0]  s_axis_tdata;
    logic           s_axis_tvalid, s_axis_tready;
    logic           core_start, core_ready, core_done, core_tvalid;
    logic [AW-1:0]  core_f_addr_a, core_f_addr_b, core_g_addr_a, core_g_addr_b;
    logic [AW-1:0]  f_addr_a, f_addr_b, g_addr_a, g_addr_b;
    logic           f_we_a, g_we_a;
    logic [DW-1:0]  f_data_a, g_data_a;
    logic           busy, job_done, job_err;
    logic [BCW-1:0] beat_count;

    tmvp_job_sequencer dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .core_start(core_start), .core_ready(core_ready), .core_done(core_done), .core_tvalid(core_tvalid),
        .core_f_addr_a(core_f_addr_a), .core_f_addr_b(core_f_addr_b),
        .core_g_addr_a(core_g_addr_a), .core_g_addr_b(core_g_addr_b),
        .f_addr_a(f_addr_a), .f_addr_b(f_addr_b), .g_addr_a(g_addr_a), .g_addr_b(g_addr_b),
        .f_we_a(f_we_a), .g_we_a(g_we_a), .f_data_a(f_data_a), .g_data_a(g_data_a),
        .busy(busy), .job_done(job_done), .job_err(job_err), .beat_count(beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // ---------------- BRAM models ----------------
    logic [DW-1:0] fmem [N];
    logic [DW-1:0] gmem [N];
    bit            mem_clr = 1'b0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < N; i++) begin
                fmem[i] <= 8'hAA;
                gmem[i] <= 8'hAA;
            end
        end else begin
            if (f_we_a === 1'b1) fmem[f_addr_a] <= f_data_a;
            if (g_we_a === 1'b1) gmem[g_addr_a] <= g_data_a;
        end
    end

    // Core address traffic is random every cycle; only meaningful in RUN.
    initial begin
        core_f_addr_a = '0; core_f_addr_b = '0; core_g_addr_a = '0; core_g_addr_b = '0;
        forever begin
            @(posedge clk); #1;
            core_f_addr_a = AW'($urandom); core_f_addr_b = AW'($urandom);
            core_g_addr_a = AW'($urandom); core_g_addr_b = AW'($urandom);
        end
    end

    int n_starts = 0;
    int n_dones  = 0;
    always @(negedge clk) begin
        if (core_start === 1'b1) n_starts++;
        if (job_done === 1'b1) n_dones++;
    end

    // ---------------- behavioural model ----------------
    // Job progress as plain counts: beats accepted (0..2R), pad words written
    // (0..2(N-R)), core stage (0 loading, 1 awaiting ready, 2 running, 3 finish).
    int m_acc = 0, m_pad = 0, m_stage = 0, m_beats = 0;
    bit m_start = 0, m_done = 0, m_err = 0, model_on = 0;

    function automatic bit exp_tready();
        return !reset && m_stage == 0 &&
               (m_acc < R || (m_acc < 2*R && m_pad == N - R));
    endfunction

    function automatic bit pad_cycle();
        return m_stage == 0 && ((m_acc == R && m_pad < N - R) ||
                                (m_acc == 2*R && m_pad < 2*(N - R)));
    endfunction

    always begin
        @(negedge clk);
        if (model_on) begin
            chk("tready", 32'(s_axis_tready), 32'(exp_tready()));
            chk("busy", 32'(busy), 32'(m_acc > 0 || m_stage > 0));
            chk("core_start", 32'(core_start), 32'(m_start));
            chk("job_done", 32'(job_done), 32'(m_done));
            chk("job_err", 32'(job_err), 32'(m_err));
            chk("beat_count", 32'(beat_count), 32'(m_beats));
            if (m_stage == 2) begin
                chk("run_f_addr_a", 32'(f_addr_a), 32'(core_f_addr_a));
                chk("run_f_addr_b", 32'(f_addr_b), 32'(core_f_addr_b));
                chk("run_g_addr_a", 32'(g_addr_a), 32'(core_g_addr_a));
                chk("run_g_addr_b", 32'(g_addr_b), 32'(core_g_addr_b));
                chk("run_we", 32'({f_we_a, g_we_a}), 32'd0);
            end else if (m_stage == 0) begin
                chk("load_addr_b", 32'({f_addr_b, g_addr_b}), 32'd0);
            end
        end
        @(posedge clk);
        if (reset) begin
            m_acc = 0; m_pad = 0; m_stage = 0; m_beats = 0;
            m_start = 0; m_done = 0; m_err = 0; model_on = 1;
        end else if (model_on) begin
            bit hs, pc;
            hs = exp_tready() && s_axis_tvalid;
            pc = pad_cycle();
            m_start = 0; m_done = 0; m_err = 0;
            case (m_stage)
                3: begin m_stage = 0; m_acc = 0; m_pad = 0; end
                2: begin
                    if (core_tvalid) m_beats = (m_beats < N) ? m_beats + 1 : N;
                    if (core_done) begin
                        m_stage = 3; m_done = 1; m_err = (m_beats != R);
                    end
                end
                1: if (core_ready) begin m_stage = 2; m_start = 1; m_beats = 0; end
                default: begin
                    if (hs) m_acc++;
                    else if (pc) m_pad++;
                    if (m_acc == 2*R && m_pad == 2*(N - R)) m_stage = 1;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] vals [2*R];

    task automatic clear_mem();
        @(posedge clk); #2; mem_clr = 1'b1;
        @(posedge clk); #2; mem_clr = 1'b0;
    endtask

    // Streams all 2R beats; abort_at >= 0 pulses reset instead of that beat.
    // Spurious core_tvalid/core_done are thrown in: they must be ignored.
    task automatic stream(input int stall_pct, input int abort_at);
        int i = 0;
        int guard = 0;
        bit aborted = 0;
        while (i < 2*R && !aborted) begin
            @(posedge clk); #2;
            core_tvalid = ($urandom_range(3) == 0);
            core_done   = ($urandom_range(7) == 0);
            if (abort_at >= 0 && i == abort_at) begin
                s_axis_tvalid = 1'b0;
                reset = 1'b1;
                @(posedge clk); #2;
                reset = 1'b0;
                aborted = 1;
            end else begin
                s_axis_tvalid = ($urandom_range(99) >= stall_pct);
                s_axis_tdata  = vals[i];
                @(negedge clk);
                if (s_axis_tvalid && s_axis_tready) i++;
                guard++;
                if (guard > 20000) begin
                    chk("stream_timeout", 32'(i), 32'(2*R));
                    aborted = 1;
                end
            end
        end
        if (!aborted) begin
            @(posedge clk); #2;
        end
        s_axis_tvalid = 1'b0;
        core_tvalid   = 1'b0;
        core_done     = 1'b0;
    endtask

    task automatic core_run(input int ready_delay, input int nbeats,
                            input int exp_bc, input bit exp_err);
        int waited = 0;
        int starts0 = n_starts;
        repeat (ready_delay) @(posedge clk);
        #2; core_ready = 1'b1;
        do begin
            @(negedge clk); waited++;
        end while (core_start !== 1'b1 && waited < 100);
        chk("start_latency", 32'(waited), 32'd2);
        @(posedge clk); #2;
        core_ready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            core_tvalid = 1'b1;
            core_done   = (b == nbeats - 1);
            @(posedge clk); #2;
        end
        core_tvalid = 1'b0;
        core_done   = 1'b0;
        waited = 0;
        do begin
            @(negedge clk); waited++;
        end while (job_done !== 1'b1 && waited < 10);
        chk("done_latency", 32'(waited), 32'd1);
        chk("final_beat_count", 32'(beat_count), 32'(exp_bc));
        chk("final_job_err", 32'(job_err), 32'(exp_err));
        chk("one_core_start", 32'(n_starts - starts0), 32'd1);
        @(posedge clk); #2;
    endtask

    task automatic check_mem();
        int bad_f = 0, bad_g = 0;
        logic [DW-1:0] ef, eg;
        for (int i = 0; i < N; i++) begin
            ef = (i < R) ? vals[i] : '0;
            eg = (i < R) ? vals[R + i] : '0;
            if (fmem[i] !== ef) bad_f++;
            if (gmem[i] !== eg) bad_g++;
        end
        chk("f_mem_mismatches", 32'(bad_f), 32'd0);
        chk("g_mem_mismatches", 32'(bad_g), 32'd0);
    endtask

    task automatic fill_vals(input bit ramp);
        for (int i = 0; i < 2*R; i++)
            vals[i] = ramp ? DW'(i % 256) : DW'($urandom);
    endtask

    initial begin
        int dones0;
        reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        core_ready = 1'b0; core_done = 1'b0; core_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_addr", 32'({f_addr_a, f_addr_b, g_addr_a, g_addr_b}), 32'd0);
        chk("rst_we", 32'({f_we_a, g_we_a}), 32'd0);
        chk("rst_data", 32'({f_data_a, g_data_a}), 32'd0);
        chk("rst_status", 32'({core_start, busy, job_done, job_err}), 32'd0);
        @(posedge clk); #2; reset = 1'b0;

        // Job 1: ramp data, no stalls, nominal beat count.
        fill_vals(1'b1);
        clear_mem();
        stream(0, -1);
        core_run(3, R, R, 1'b0);
        chk("f0", 32'(fmem[0]), 32'd0);
        chk("f508", 32'(fmem[508]), 32'd252);
        chk("f509", 32'(fmem[509]), 32'd0);
        chk("f511", 32'(fmem[511]), 32'd0);
        chk("g0", 32'(gmem[0]), 32'd253);
        chk("g511", 32'(gmem[511]), 32'd0);
        check_mem();

        // Job 2: ramp data with stalls, core_ready late, overflowing beats.
        clear_mem();
        stream(30, -1);
        core_run(23, 600, N, 1'b1);
        check_mem();

        // Job 3: random data with stalls, one beat short.
        fill_vals(1'b0);
        clear_mem();
        stream(30, -1);
        core_run(3, R - 1, R - 1, 1'b1);
        check_mem();

        // Job 4: reset lands while g address 100 is next.
        fill_vals(1'b0);
        dones0 = n_dones;
        stream(20, R + 100);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tready", 32'(s_axis_tready), 32'd1);
        chk("abort_beat_count", 32'(beat_count), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(n_dones - dones0), 32'd0);

        // Job 5: full job after the abort.
        clear_mem();
        stream(10, -1);
        core_run(5, R, R, 1'b0);
        check_mem();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
